xgmii_decoder: RTL and testbench

//  Receive-side 64b/66b decoder (IEEE 802.3 Cl.49) for the 10GBASE-R PCS. Takes the descrambled
//  32-bit half-blocks plus the 2-bit sync header from the descrambler and regenerates 32-bit XGMII
//  RXD/RXC toward the MAC. Validates block types and frame sequencing, replacing bad blocks with /E/.

---
 rtl/xgmii_pkg.sv | 47 ++++
 rtl/xgmii_ctrl_code_map.sv | 13 +
 rtl/xgmii_decoder.sv | 134 +++++++++++++
 tb/tb_xgmii_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII characters, 10GBASE-R block types and sync headers shared by the encoder and decoder
package xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;

   localparam logic [6:0] CTRL_IDLE  = 7'h00;
   localparam logic [6:0] CTRL_ERROR = 7'h1E;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam logic [7:0] TYPE_CTRL    = 8'h1E;
   localparam logic [7:0] TYPE_START_0 = 8'h78;
   localparam logic [7:0] TYPE_START_4 = 8'h33;

   // Terminate kinds occupy codes 0..7 so the low three bits give the /T/ lane directly
   typedef enum logic [3:0] {
      BLOCK_TERM_0, BLOCK_TERM_1, BLOCK_TERM_2, BLOCK_TERM_3,
      BLOCK_TERM_4, BLOCK_TERM_5, BLOCK_TERM_6, BLOCK_TERM_7,
      BLOCK_CTRL, BLOCK_START_0, BLOCK_START_4, BLOCK_DATA, BLOCK_BAD
   } block_t;

   typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;

   function automatic block_t block_type(input logic [1:0] hdr, input logic [7:0] tb);
      block_t t;
      case (tb)
         TYPE_CTRL:    t = BLOCK_CTRL;
         TYPE_START_0: t = BLOCK_START_0;
         TYPE_START_4: t = BLOCK_START_4;
         8'h87:        t = BLOCK_TERM_0;
         8'h99:        t = BLOCK_TERM_1;
         8'hAA:        t = BLOCK_TERM_2;
         8'hB4:        t = BLOCK_TERM_3;
         8'hCC:        t = BLOCK_TERM_4;
         8'hD2:        t = BLOCK_TERM_5;
         8'hE1:        t = BLOCK_TERM_6;
         8'hFF:        t = BLOCK_TERM_7;
         default:      t = BLOCK_BAD;
      endcase
      block_type = hdr == SYNC_DATA ? BLOCK_DATA : hdr == SYNC_CTRL ? t : BLOCK_BAD;
   endfunction

endpackage

// File: rtl/xgmii_ctrl_code_map.sv
// xgmii_ctrl_code_map: maps one 7-bit 10GBASE-R control code to its XGMII character
module xgmii_ctrl_code_map
   import xgmii_pkg::*;
(
   input  logic [6:0] code_i,
   output logic [7:0] char_o,
   output logic       err_o
);

   assign err_o  = code_i != CTRL_IDLE;
   assign char_o = err_o ? XGMII_ERROR : XGMII_IDLE;

endmodule

// File: rtl/xgmii_decoder.sv
// xgmii_decoder: 64b/66b receive decoder turning descrambled half-blocks into 32-bit XGMII RXD/RXC
module xgmii_decoder
   import xgmii_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int HDR_WIDTH  = 2,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_encoded_data,
   input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
   input  logic                  i_encoded_data_valid,
   input  logic                  i_block_lock,
   output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
   output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
   output logic                  o_xgmii_valid,
   output logic                  o_decode_err
);

   localparam int BLK_W = 2 * DATA_WIDTH;
   localparam int LANES = 2 * CTRL_WIDTH;
   localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{XGMII_IDLE}};

   logic                  phase_q, pend_q;
   rx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] even_q, hi_rxd_q;
   logic [CTRL_WIDTH-1:0] hi_rxc_q;
   logic [HDR_WIDTH-1:0]  hdr_q;
   logic [BLK_W-1:0]      blk, blk_sh, dec_rxd, out_rxd;
   logic [LANES-1:0]      dec_rxc, out_rxc, map_err;
   logic [7:0]            map_char [LANES];
   block_t                btype;
   logic                  code_err, malformed, seq_err, blk_err;
   logic                  is_term, is_ctrl, is_start, is_data;

   assign blk    = {i_encoded_data, even_q};
   assign blk_sh = {8'h00, blk[BLK_W-1:8]};

   // Every lane's code field sits at bit 8+7*lane regardless of block type, so one mapper per lane suffices
   for (genvar l = 0; l < LANES; l++) begin : g_map
      xgmii_ctrl_code_map u_map (
         .code_i (blk[8 + 7*l +: 7]),
         .char_o (map_char[l]),
         .err_o  (map_err[l])
      );
   end

   // Classify the block, build its eight lanes, then apply the frame-sequence rules
   always_comb begin
      btype    = block_type(hdr_q, blk[7:0]);
      is_term  = ~btype[3];
      is_ctrl  = btype == BLOCK_CTRL;
      is_start = btype inside {BLOCK_START_0, BLOCK_START_4};
      is_data  = btype == BLOCK_DATA;
      dec_rxd  = blk;
      dec_rxc  = '0;
      code_err = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (is_ctrl) begin
            dec_rxd[8*i +: 8] = map_char[i];
            dec_rxc[i]        = 1'b1;
            code_err          = code_err | (map_err[i] & (blk[8 + 7*i +: 7] != CTRL_ERROR));
         end else if (btype == BLOCK_START_0 && i == 0) begin
            dec_rxd[7:0] = XGMII_START;
            dec_rxc[0]   = 1'b1;
         end else if (btype == BLOCK_START_4 && i < 5) begin
            dec_rxd[8*i +: 8] = i == 4 ? XGMII_START : map_char[i];
            dec_rxc[i]        = 1'b1;
            code_err          = code_err | (i < 4 && map_err[i]);
         end else if (is_term) begin
            dec_rxd[8*i +: 8] = i < int'(btype[2:0]) ? blk_sh[8*i +: 8] :
                                i == int'(btype[2:0]) ? XGMII_TERM : map_char[i];
            dec_rxc[i]        = i >= int'(btype[2:0]);
            code_err          = code_err | (i > int'(btype[2:0]) && map_err[i]);
         end
      end
      malformed = btype == BLOCK_BAD || code_err;
      seq_err   = state_q == RX_IDLE ? is_data || is_term : is_ctrl || is_start;
      blk_err   = malformed || seq_err;
      state_d   = !malformed && (state_q == RX_IDLE ? is_start : is_data) ? RX_FRAME : RX_IDLE;
      out_rxd   = blk_err ? {LANES{XGMII_ERROR}} : dec_rxd;
      out_rxc   = blk_err ? '1 : dec_rxc;
   end

   // Half-block phase, frame FSM and the two-cycle low/high output pipeline
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_q       <= 1'b0;
         pend_q        <= 1'b0;
         state_q       <= RX_IDLE;
         even_q        <= '0;
         hdr_q         <= '0;
         hi_rxd_q      <= IDLE_WORD;
         hi_rxc_q      <= '1;
         o_xgmii_rxd   <= IDLE_WORD;
         o_xgmii_rxc   <= '1;
         o_xgmii_valid <= 1'b0;
         o_decode_err  <= 1'b0;
      end else if (!i_block_lock) begin
         phase_q       <= 1'b0;
         pend_q        <= 1'b0;
         state_q       <= RX_IDLE;
         o_xgmii_rxd   <= IDLE_WORD;
         o_xgmii_rxc   <= '1;
         o_xgmii_valid <= i_encoded_data_valid;
         o_decode_err  <= 1'b0;
      end else begin
         if (i_encoded_data_valid)
            phase_q <= ~phase_q;
         if (i_encoded_data_valid && !phase_q) begin
            even_q <= i_encoded_data;
            hdr_q  <= i_sync_hdr;
         end
         if (i_encoded_data_valid && phase_q) begin
            o_xgmii_rxd   <= out_rxd[DATA_WIDTH-1:0];
            o_xgmii_rxc   <= out_rxc[CTRL_WIDTH-1:0];
            o_xgmii_valid <= 1'b1;
            o_decode_err  <= blk_err;
            hi_rxd_q      <= out_rxd[BLK_W-1:DATA_WIDTH];
            hi_rxc_q      <= out_rxc[LANES-1:CTRL_WIDTH];
            pend_q        <= 1'b1;
            state_q       <= state_d;
         end else begin
            o_xgmii_rxd   <= pend_q ? hi_rxd_q : IDLE_WORD;
            o_xgmii_rxc   <= pend_q ? hi_rxc_q : '1;
            o_xgmii_valid <= pend_q;
            o_decode_err  <= 1'b0;
            pend_q        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xgmii_decoder.sv
// tb_xgmii_decoder: directed and randomized block stream against a lane-level reference model
module tb_xgmii_decoder;

   localparam int K_DATA = 0, K_CTRL = 1, K_S0 = 2, K_S4 = 3, K_TERM = 4;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  c;
      logic        e;
   } word_t;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic [31:0] din = '0;
   logic [1:0]  hdr = '0;
   logic        vin = 1'b0, lock = 1'b0;
   logic [31:0] rxd;
   logic [3:0]  rxc;
   logic        vout, derr;
   int          checks = 0, errors = 0;
   word_t       expq[$];
   logic        in_frame = 1'b0;
   logic [7:0]  term_type [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

   localparam word_t IDLE_W = {32'h07070707, 4'hF, 1'b0};
   localparam word_t ERR_LO = {32'hFEFEFEFE, 4'hF, 1'b1};
   localparam word_t ERR_HI = {32'hFEFEFEFE, 4'hF, 1'b0};

   always #5 clk = ~clk;

   xgmii_decoder dut (
      .i_clk                (clk),
      .i_reset_n            (rst_n),
      .i_encoded_data       (din),
      .i_sync_hdr           (hdr),
      .i_encoded_data_valid (vin),
      .i_block_lock         (lock),
      .o_xgmii_rxd          (rxd),
      .o_xgmii_rxc          (rxc),
      .o_xgmii_valid        (vout),
      .o_decode_err         (derr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock with the given input word, then check whatever the DUT should show after that edge
   task automatic step(input logic [31:0] d, input logic [1:0] h, input logic v);
      word_t w;
      din = d;
      hdr = h;
      vin = v;
      @(posedge clk);
      #1;
      if (!lock) begin
         chk("lock_valid", 64'(vout), 64'(v));
         chk("lock_idle", 64'({rxd, rxc, derr}), 64'(IDLE_W));
      end else if (expq.size() > 0) begin
         w = expq.pop_front();
         chk("out_valid", 64'(vout), 64'd1);
         chk("out_word", 64'({rxd, rxc, derr}), 64'(w));
      end else
         chk("gap_valid", 64'(vout), 64'd0);
   endtask

   task automatic send_raw(input logic [63:0] b, input logic [1:0] h, input word_t lo, input word_t hi);
      step(b[31:0], h, 1'b1);
      expq.push_back(lo);
      expq.push_back(hi);
      step(b[63:32], 2'b00, 1'b1);
   endtask

   // reference model: builds a block from lane contents, encodes it and predicts the XGMII words
   task automatic send_block(input int kind, input int k, input int corrupt, input int gap);
      logic [63:0] b, r;
      logic [1:0]  h;
      logic [7:0]  ch [8];
      logic        cc [8], cl [8], bad, start, err;
      logic [6:0]  code [8], pick;
      logic [7:0]  t;
      int          n, ln;
      word_t       lo, hi;
      r   = {$urandom, $urandom};
      b   = '0;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ch[i]   = r[8*i +: 8];
         cc[i]   = 1'b0;
         code[i] = 7'h00;
         cl[i]   = (kind == K_CTRL) || (kind == K_S4 && i < 4) || (kind == K_TERM && i > k);
         if (kind == K_CTRL && r[i])
            code[i] = 7'h1E;
      end
      if (corrupt == 3) begin
         n = $urandom_range(0, 7);
         do pick = 7'($urandom_range(1, 127)); while (pick == 7'h1E);
         for (int j = 0; j < 8; j++) begin
            ln = (n + j) % 8;
            if (!bad && cl[ln]) begin
               code[ln] = pick;
               bad      = 1'b1;
            end
         end
      end
      h = kind == K_DATA ? 2'b01 : 2'b10;
      if (kind == K_DATA)
         b = r;
      else if (kind == K_CTRL) begin
         b[7:0] = 8'h1E;
         for (int i = 0; i < 8; i++) begin
            b[8 + 7*i +: 7] = code[i];
            ch[i] = code[i] == 7'h00 ? 8'h07 : 8'hFE;
            cc[i] = 1'b1;
         end
      end else if (kind == K_S0) begin
         b      = r;
         b[7:0] = 8'h78;
         ch[0]  = 8'hFB;
         cc[0]  = 1'b1;
      end else if (kind == K_S4) begin
         b[7:0] = 8'h33;
         for (int i = 0; i < 4; i++) begin
            b[8 + 7*i +: 7] = code[i];
            ch[i] = 8'h07;
            cc[i] = 1'b1;
         end
         ch[4] = 8'hFB;
         cc[4] = 1'b1;
         for (int i = 5; i < 8; i++)
            b[8*i +: 8] = r[8*i +: 8];
      end else begin
         b[7:0] = term_type[k];
         for (int i = 0; i < k; i++)
            b[8 + 8*i +: 8] = r[8*i +: 8];
         ch[k] = 8'hFD;
         cc[k] = 1'b1;
         for (int j = k + 1; j < 8; j++) begin
            b[8 + 8*k + (7 - k) + 7*(j - k - 1) +: 7] = code[j];
            ch[j] = 8'h07;
            cc[j] = 1'b1;
         end
      end
      if (corrupt == 1) begin
         h   = $urandom_range(0, 1) ? 2'b00 : 2'b11;
         bad = 1'b1;
      end else if (corrupt == 2) begin
         do t = 8'($urandom); while (t inside {8'h1E, 8'h78, 8'h33, 8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF});
         h      = 2'b10;
         b[7:0] = t;
         bad    = 1'b1;
      end
      start    = kind == K_S0 || kind == K_S4;
      err      = bad || (in_frame ? (kind == K_CTRL || start) : (kind == K_DATA || kind == K_TERM));
      in_frame = !bad && (in_frame ? kind == K_DATA : start);
      lo = err ? ERR_LO : {ch[3], ch[2], ch[1], ch[0], cc[3], cc[2], cc[1], cc[0], 1'b0};
      hi = err ? ERR_HI : {ch[7], ch[6], ch[5], ch[4], cc[7], cc[6], cc[5], cc[4], 1'b0};
      step(b[31:0], h, 1'b1);
      for (int g = 0; g < gap; g++)
         step($urandom, 2'($urandom), 1'b0);
      expq.push_back(lo);
      expq.push_back(hi);
      step(b[63:32], 2'($urandom), 1'b1);
   endtask

   initial begin
      int sel, kind, corrupt, gap;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_async", 64'({rxd, rxc, vout, derr}), {27'd0, 32'h07070707, 4'hF, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step(32'h0, 2'b00, 1'b0);
      lock = 1'b1;

      // idle control blocks
      send_raw({56'h0, 8'h1E}, 2'b10, IDLE_W, IDLE_W);
      send_raw({56'h0, 8'h1E}, 2'b10, IDLE_W, IDLE_W);

      // start, data, terminate at lane 0
      send_raw({56'h07060504030201, 8'h78}, 2'b10, {32'h030201FB, 4'h1, 1'b0}, {32'h07060504, 4'h0, 1'b0});
      send_raw(64'h0F0E0D0C0B0A0908, 2'b01, {32'h0B0A0908, 4'h0, 1'b0}, {32'h0F0E0D0C, 4'h0, 1'b0});
      send_raw({56'h0, 8'h87}, 2'b10, {32'h070707FD, 4'hF, 1'b0}, IDLE_W);

      // start in lane 4, terminate in lane 7
      send_raw({56'h0, 8'h1E}, 2'b10, IDLE_W, IDLE_W);
      send_raw({24'hC7B6A5, 32'h0, 8'h33}, 2'b10, IDLE_W, {32'hC7B6A5FB, 4'h1, 1'b0});
      send_raw({56'h17161514131211, 8'hFF}, 2'b10, {32'h14131211, 4'h0, 1'b0}, {32'hFD171615, 4'h8, 1'b0});

      // data while idle, bad header, bad type byte
      send_raw(64'h1122334455667788, 2'b01, ERR_LO, ERR_HI);
      send_raw(64'h1122334455667788, 2'b11, ERR_LO, ERR_HI);
      send_raw({56'h0, 8'h4B}, 2'b10, ERR_LO, ERR_HI);

      // start accepted (still idle), second start and following data rejected
      send_raw({56'h37363534333231, 8'h78}, 2'b10, {32'h333231FB, 4'h1, 1'b0}, {32'h37363534, 4'h0, 1'b0});
      send_raw({56'h37363534333231, 8'h78}, 2'b10, ERR_LO, ERR_HI);
      send_raw(64'h0F0E0D0C0B0A0908, 2'b01, ERR_LO, ERR_HI);

      // lock lost after an even word; the next word after relock is an even word
      step(32'h00000078, 2'b10, 1'b1);
      lock = 1'b0;
      expq.delete();
      step(32'hDEADBEEF, 2'b10, 1'b1);
      step(32'hDEADBEEF, 2'b10, 1'b0);
      lock = 1'b1;
      send_raw({56'hA1A2A3A4A5A6A7, 8'h78}, 2'b10, {32'hA5A6A7FB, 4'h1, 1'b0}, {32'hA1A2A3A4, 4'h0, 1'b0});
      send_raw({56'h0, 8'h87}, 2'b10, {32'h070707FD, 4'hF, 1'b0}, IDLE_W);
      in_frame = 1'b0;

      // randomized block stream with gaps, sequence violations and corruptions
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 99);
         if (!in_frame)
            kind = sel < 45 ? K_CTRL : sel < 85 ? ($urandom_range(0, 1) ? K_S0 : K_S4) : sel < 93 ? K_DATA : K_TERM;
         else
            kind = sel < 60 ? K_DATA : sel < 88 ? K_TERM : sel < 94 ? K_CTRL : K_S0;
         corrupt = $urandom_range(0, 99) < 8 ? $urandom_range(1, 3) : 0;
         gap     = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
         send_block(kind, $urandom_range(0, 7), corrupt, gap);
         if ($urandom_range(0, 9) == 0)
            step($urandom, 2'($urandom), 1'b0);
      end

      repeat (3) step(32'h0, 2'b00, 1'b0);
      chk("drain", 64'(expq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
